// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for the RV32I core: sequences fetch, decode, execute,
// memory, writeback, trap and debug-halt states and drives all datapath controls.
module multicycle_control_fsm #(
  parameter int unsigned         ALUOP_W      = 5,
  parameter logic [ALUOP_W-1:0]  ALU_ADD      = '0,
  parameter int unsigned         MEM_LATENCY  = 0,
  parameter bit                  HALT_ON_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               opcode_load,
  input  logic               opcode_miscmem,
  input  logic               opcode_opimm,
  input  logic               opcode_auipc,
  input  logic               opcode_store,
  input  logic               opcode_op,
  input  logic               opcode_lui,
  input  logic               opcode_branch,
  input  logic               opcode_jalr,
  input  logic               opcode_jal,
  input  logic               opcode_system,
  input  logic               invalid_inst,
  input  logic               ialign,
  input  logic               mem_malign,
  input  logic               mem_fc,
  input  logic [ALUOP_W-1:0] aluop_in,
  input  logic               branch_taken,
  input  logic               mem_ready,
  input  logic               halt_req,
  input  logic               resume_req,
  output logic               write_pc,
  output logic               write_ir,
  output logic               write_rd,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               addr_sel,
  output logic               rd_sel,
  output logic [1:0]         alu_insel1,
  output logic [1:0]         alu_insel2,
  output logic               trap_valid,
  output logic [2:0]         trap_cause,
  output logic               halted
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_JUMP,
    S_MEM,
    S_WB,
    S_TRAP_IALIGN,
    S_TRAP_INVALID,
    S_TRAP_MALIGN,
    S_TRAP_FAULT,
    S_TRAP_SYSTEM,
    S_HALT
  } state_e;

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((MEM_LATENCY == 0) ? 0 : MEM_LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             first_cycle;
  logic             access_done;
  state_e           trap_next;

  // Counter saturates so a long mem_ready wait never looks like a first cycle again.
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign first_cycle = (cnt_q == '0);
  assign access_done = (MEM_LATENCY == 0) ? mem_ready : (cnt_q == CNT_LAST);
  assign trap_next   = HALT_ON_TRAP ? S_HALT : S_FETCH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    write_pc   = 1'b0;
    write_ir   = 1'b0;
    write_rd   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = ALU_ADD;
    addr_sel   = 1'b0;
    rd_sel     = 1'b0;
    alu_insel1 = 2'd0;
    alu_insel2 = 2'd0;
    trap_valid = 1'b0;
    trap_cause = 3'd0;
    halted     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (first_cycle && halt_req) begin
          state_d = S_HALT;
        end else if (first_cycle && ialign) begin
          state_d = S_TRAP_IALIGN;
        end else begin
          mem_read = 1'b1;
          if (access_done) begin
            write_ir   = 1'b1;
            write_pc   = 1'b1;
            alu_insel1 = 2'd1;
            alu_insel2 = 2'd2;
            state_d    = S_DECODE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_DECODE: begin
        state_d = invalid_inst ? S_TRAP_INVALID : S_EXECUTE;
      end

      S_EXECUTE: begin
        state_d = S_FETCH;
        if (opcode_op) begin
          alu_op   = aluop_in;
          write_rd = 1'b1;
        end else if (opcode_opimm) begin
          alu_op     = aluop_in;
          alu_insel2 = 2'd1;
          write_rd   = 1'b1;
        end else if (opcode_lui) begin
          alu_insel1 = 2'd2;
          alu_insel2 = 2'd1;
          write_rd   = 1'b1;
        end else if (opcode_auipc) begin
          alu_insel1 = 2'd3;
          alu_insel2 = 2'd1;
          write_rd   = 1'b1;
        end else if (opcode_jal || opcode_jalr) begin
          alu_insel1 = 2'd1;
          alu_insel2 = 2'd3;
          write_rd   = 1'b1;
          state_d    = S_JUMP;
        end else if (opcode_branch) begin
          alu_op = aluop_in;
          if (branch_taken) state_d = S_JUMP;
        end else if (opcode_load || opcode_store) begin
          alu_insel2 = 2'd1;
          state_d    = S_MEM;
        end else if (opcode_system) begin
          state_d = S_TRAP_SYSTEM;
        end else if (opcode_miscmem) begin
          state_d = S_FETCH;
        end
      end

      S_JUMP: begin
        write_pc   = 1'b1;
        alu_insel1 = opcode_jalr ? 2'd0 : 2'd3;
        alu_insel2 = 2'd1;
        state_d    = S_FETCH;
      end

      S_MEM: begin
        if (first_cycle && mem_malign) begin
          state_d = S_TRAP_MALIGN;
        end else begin
          addr_sel   = 1'b1;
          alu_insel2 = 2'd1;
          // A fault pre-empts completion and suppresses the strobe in the same cycle.
          if (mem_fc) begin
            state_d = S_TRAP_FAULT;
          end else begin
            mem_read  = opcode_load;
            mem_write = opcode_store;
            if (access_done) begin
              state_d = opcode_load ? S_WB : S_FETCH;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
      end

      S_WB: begin
        write_rd = 1'b1;
        rd_sel   = 1'b1;
        state_d  = S_FETCH;
      end

      S_TRAP_IALIGN, S_TRAP_INVALID, S_TRAP_MALIGN, S_TRAP_FAULT, S_TRAP_SYSTEM: begin
        trap_valid = 1'b1;
        unique case (state_q)
          S_TRAP_IALIGN:  trap_cause = 3'd0;
          S_TRAP_INVALID: trap_cause = 3'd1;
          S_TRAP_MALIGN:  trap_cause = 3'd2;
          S_TRAP_FAULT:   trap_cause = 3'd3;
          default:        trap_cause = 3'd4;
        endcase
        state_d = trap_next;
      end

      S_HALT: begin
        halted = 1'b1;
        if (resume_req && !halt_req) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    if (!rst_n) begin
      write_pc   = 1'b0;
      write_ir   = 1'b0;
      write_rd   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_op     = '0;
      addr_sel   = 1'b0;
      rd_sel     = 1'b0;
      alu_insel1 = 2'd0;
      alu_insel2 = 2'd0;
      trap_valid = 1'b0;
      trap_cause = 3'd0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: one instance with handshake memory
// and halt-on-trap, one with fixed 2-cycle memory, trap-to-fetch and nonzero ALU_ADD.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       write_pc;
    logic       write_ir;
    logic       write_rd;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] alu_op;
    logic       addr_sel;
    logic       rd_sel;
    logic [1:0] insel1;
    logic [1:0] insel2;
    logic       trap_valid;
    logic [2:0] trap_cause;
    logic       halted;
  } out_t;

  typedef struct packed {
    logic       ld, mm, oi, au, st, op, lu, br, jr, jl, sy;
    logic       inv, ia, mal, fc;
    logic [4:0] aluop;
    logic       taken, rdy, hreq, rres;
  } in_t;

  typedef struct {
    bit    sel;
    out_t  exp;
    string tag;
  } sb_t;

  localparam bit   A    = 1'b0;
  localparam bit   B    = 1'b1;
  localparam out_t ZERO = '0;

  logic clk = 1'b0;
  logic rst_n;
  in_t  ina, inb;
  out_t oa, ob;
  sb_t  sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  logic       a_wpc, a_wir, a_wrd, a_mr, a_mw, a_as, a_rs, a_tv, a_h;
  logic [4:0] a_alu;
  logic [1:0] a_i1, a_i2;
  logic [2:0] a_tc;
  logic       b_wpc, b_wir, b_wrd, b_mr, b_mw, b_as, b_rs, b_tv, b_h;
  logic [4:0] b_alu;
  logic [1:0] b_i1, b_i2;
  logic [2:0] b_tc;

  assign oa = {a_wpc, a_wir, a_wrd, a_mr, a_mw, a_alu, a_as, a_rs, a_i1, a_i2, a_tv, a_tc, a_h};
  assign ob = {b_wpc, b_wir, b_wrd, b_mr, b_mw, b_alu, b_as, b_rs, b_i1, b_i2, b_tv, b_tc, b_h};

  multicycle_control_fsm #(.ALUOP_W(5), .ALU_ADD(5'd0), .MEM_LATENCY(0), .HALT_ON_TRAP(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .opcode_load(ina.ld), .opcode_miscmem(ina.mm), .opcode_opimm(ina.oi), .opcode_auipc(ina.au),
    .opcode_store(ina.st), .opcode_op(ina.op), .opcode_lui(ina.lu), .opcode_branch(ina.br),
    .opcode_jalr(ina.jr), .opcode_jal(ina.jl), .opcode_system(ina.sy),
    .invalid_inst(ina.inv), .ialign(ina.ia), .mem_malign(ina.mal), .mem_fc(ina.fc),
    .aluop_in(ina.aluop), .branch_taken(ina.taken), .mem_ready(ina.rdy),
    .halt_req(ina.hreq), .resume_req(ina.rres),
    .write_pc(a_wpc), .write_ir(a_wir), .write_rd(a_wrd), .mem_read(a_mr), .mem_write(a_mw),
    .alu_op(a_alu), .addr_sel(a_as), .rd_sel(a_rs), .alu_insel1(a_i1), .alu_insel2(a_i2),
    .trap_valid(a_tv), .trap_cause(a_tc), .halted(a_h)
  );

  multicycle_control_fsm #(.ALUOP_W(5), .ALU_ADD(5'd3), .MEM_LATENCY(2), .HALT_ON_TRAP(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .opcode_load(inb.ld), .opcode_miscmem(inb.mm), .opcode_opimm(inb.oi), .opcode_auipc(inb.au),
    .opcode_store(inb.st), .opcode_op(inb.op), .opcode_lui(inb.lu), .opcode_branch(inb.br),
    .opcode_jalr(inb.jr), .opcode_jal(inb.jl), .opcode_system(inb.sy),
    .invalid_inst(inb.inv), .ialign(inb.ia), .mem_malign(inb.mal), .mem_fc(inb.fc),
    .aluop_in(inb.aluop), .branch_taken(inb.taken), .mem_ready(inb.rdy),
    .halt_req(inb.hreq), .resume_req(inb.rres),
    .write_pc(b_wpc), .write_ir(b_wir), .write_rd(b_wrd), .mem_read(b_mr), .mem_write(b_mw),
    .alu_op(b_alu), .addr_sel(b_as), .rd_sel(b_rs), .alu_insel1(b_i1), .alu_insel2(b_i2),
    .trap_valid(b_tv), .trap_cause(b_tc), .halted(b_h)
  );

  function automatic out_t o_idle(input logic [4:0] alu);
    out_t o = '0;
    o.alu_op = alu;
    return o;
  endfunction

  function automatic out_t o_frd(input logic [4:0] alu);
    out_t o = o_idle(alu);
    o.mem_read = 1'b1;
    return o;
  endfunction

  function automatic out_t o_fdone(input logic [4:0] alu);
    out_t o = o_frd(alu);
    o.write_ir = 1'b1;
    o.write_pc = 1'b1;
    o.insel1   = 2'd1;
    o.insel2   = 2'd2;
    return o;
  endfunction

  function automatic out_t o_ex(input logic [4:0] alu, input logic wrd,
                                input logic [1:0] i1, input logic [1:0] i2);
    out_t o = o_idle(alu);
    o.write_rd = wrd;
    o.insel1   = i1;
    o.insel2   = i2;
    return o;
  endfunction

  function automatic out_t o_jump(input logic [1:0] i1, input logic [4:0] alu);
    out_t o = o_idle(alu);
    o.write_pc = 1'b1;
    o.insel1   = i1;
    o.insel2   = 2'd1;
    return o;
  endfunction

  function automatic out_t o_mem(input logic rd, input logic wr, input logic [4:0] alu);
    out_t o = o_idle(alu);
    o.addr_sel  = 1'b1;
    o.insel2    = 2'd1;
    o.mem_read  = rd;
    o.mem_write = wr;
    return o;
  endfunction

  function automatic out_t o_wb(input logic [4:0] alu);
    out_t o = o_idle(alu);
    o.write_rd = 1'b1;
    o.rd_sel   = 1'b1;
    return o;
  endfunction

  function automatic out_t o_trap(input logic [2:0] c, input logic [4:0] alu);
    out_t o = o_idle(alu);
    o.trap_valid = 1'b1;
    o.trap_cause = c;
    return o;
  endfunction

  function automatic out_t o_halt(input logic [4:0] alu);
    out_t o = o_idle(alu);
    o.halted = 1'b1;
    return o;
  endfunction

  // Called at a falling edge with inputs already driven; checks this cycle's outputs.
  task automatic cyc(input bit sel, input out_t e, input string tag);
    sb_t  it;
    out_t got;
    sbq.push_back('{sel: sel, exp: e, tag: tag});
    #1;
    it  = sbq.pop_front();
    got = it.sel ? ob : oa;
    n_tests++;
    assert (got === it.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", it.tag, got, it.exp);
      end
    @(negedge clk);
  endtask

  initial begin
    ina = '0;
    inb = '0;
    rst_n = 1'b0;
    @(negedge clk);
    cyc(A, ZERO, "a_rst");
    cyc(B, ZERO, "b_rst0");
    rst_n = 1'b1;

    // register-register op with three-cycle fetch handshake
    ina.op = 1'b1; ina.aluop = 5'h0a;
    cyc(A, o_frd(0), "a_op_f0");
    cyc(A, o_frd(0), "a_op_f1");
    ina.rdy = 1'b1;
    cyc(A, o_fdone(0), "a_op_f2");
    ina.rdy = 1'b0;
    cyc(A, o_idle(0), "a_op_dec");
    cyc(A, o_ex(5'h0a, 1'b1, 2'd0, 2'd0), "a_op_ex");

    // branch taken
    ina.op = 1'b0; ina.br = 1'b1; ina.taken = 1'b1; ina.aluop = 5'h03; ina.rdy = 1'b1;
    cyc(A, o_fdone(0), "a_bt_f");
    ina.rdy = 1'b0;
    cyc(A, o_idle(0), "a_bt_dec");
    cyc(A, o_ex(5'h03, 1'b0, 2'd0, 2'd0), "a_bt_ex");
    cyc(A, o_jump(2'd3, 0), "a_bt_jmp");

    // branch not taken
    ina.taken = 1'b0; ina.rdy = 1'b1;
    cyc(A, o_fdone(0), "a_bn_f");
    ina.rdy = 1'b0;
    cyc(A, o_idle(0), "a_bn_dec");
    cyc(A, o_ex(5'h03, 1'b0, 2'd0, 2'd0), "a_bn_ex");
    cyc(A, o_frd(0), "a_bn_next");

    // misaligned store traps before any strobe, then halts
    ina.br = 1'b0; ina.st = 1'b1; ina.mal = 1'b1; ina.rdy = 1'b1;
    cyc(A, o_fdone(0), "a_sm_f");
    ina.rdy = 1'b0;
    cyc(A, o_idle(0), "a_sm_dec");
    cyc(A, o_ex(0, 1'b0, 2'd0, 2'd1), "a_sm_ex");
    cyc(A, o_idle(0), "a_sm_mem");
    cyc(A, o_trap(3'd2, 0), "a_sm_trap");
    cyc(A, o_halt(0), "a_sm_halt");
    ina.hreq = 1'b1; ina.rres = 1'b1;
    cyc(A, o_halt(0), "a_both_req");
    ina.hreq = 1'b0;
    cyc(A, o_halt(0), "a_resume");
    ina.rres = 1'b0;
    cyc(A, o_frd(0), "a_sm_refetch");

    // jal with halt_req raised mid-instruction
    ina.st = 1'b0; ina.mal = 1'b0; ina.jl = 1'b1; ina.rdy = 1'b1;
    cyc(A, o_fdone(0), "a_jal_f");
    ina.rdy = 1'b0;
    cyc(A, o_idle(0), "a_jal_dec");
    ina.hreq = 1'b1;
    cyc(A, o_ex(0, 1'b1, 2'd1, 2'd3), "a_jal_ex");
    cyc(A, o_jump(2'd3, 0), "a_jal_jmp");
    cyc(A, o_idle(0), "a_hlt_fetch");
    cyc(A, o_halt(0), "a_hlt");
    ina.hreq = 1'b0; ina.rres = 1'b1;
    cyc(A, o_halt(0), "a_hlt_res");
    ina.rres = 1'b0;
    cyc(A, o_frd(0), "a_hlt_refetch");

    // jalr target uses rs1
    ina.jl = 1'b0; ina.jr = 1'b1; ina.rdy = 1'b1;
    cyc(A, o_fdone(0), "a_jalr_f");
    ina.rdy = 1'b0;
    cyc(A, o_idle(0), "a_jalr_dec");
    cyc(A, o_ex(0, 1'b1, 2'd1, 2'd3), "a_jalr_ex");
    cyc(A, o_jump(2'd0, 0), "a_jalr_jmp");

    // PC misaligned at fetch entry
    ina.jr = 1'b0; ina.ia = 1'b1;
    cyc(A, o_idle(0), "a_ia_f");
    cyc(A, o_trap(3'd0, 0), "a_ia_trap");
    cyc(A, o_halt(0), "a_ia_halt");
    ina.ia = 1'b0; ina.rres = 1'b1;
    cyc(A, o_halt(0), "a_ia_res");
    ina.rres = 1'b0;
    cyc(A, o_frd(0), "a_ia_refetch");

    // load with handshake memory
    ina.ld = 1'b1; ina.rdy = 1'b1;
    cyc(A, o_fdone(0), "a_ld_f");
    ina.rdy = 1'b0;
    cyc(A, o_idle(0), "a_ld_dec");
    cyc(A, o_ex(0, 1'b0, 2'd0, 2'd1), "a_ld_ex");
    cyc(A, o_mem(1'b1, 1'b0, 0), "a_ld_m0");
    ina.rdy = 1'b1;
    cyc(A, o_mem(1'b1, 1'b0, 0), "a_ld_m1");
    ina.rdy = 1'b0;
    cyc(A, o_wb(0), "a_ld_wb");
    cyc(A, o_frd(0), "a_ld_next");

    // illegal instruction
    ina.ld = 1'b0; ina.rdy = 1'b1;
    cyc(A, o_fdone(0), "a_inv_f");
    ina.rdy = 1'b0; ina.inv = 1'b1;
    cyc(A, o_idle(0), "a_inv_dec");
    cyc(A, o_trap(3'd1, 0), "a_inv_trap");
    cyc(A, o_halt(0), "a_inv_halt");
    ina.inv = 1'b0;

    rst_n = 1'b0;
    cyc(B, ZERO, "b_rst1");
    rst_n = 1'b1;

    // fixed-latency load: 7 cycles total
    inb.ld = 1'b1;
    cyc(B, o_frd(3), "b_ld_f0");
    cyc(B, o_fdone(3), "b_ld_f1");
    cyc(B, o_idle(3), "b_ld_dec");
    cyc(B, o_ex(3, 1'b0, 2'd0, 2'd1), "b_ld_ex");
    cyc(B, o_mem(1'b1, 1'b0, 3), "b_ld_m0");
    cyc(B, o_mem(1'b1, 1'b0, 3), "b_ld_m1");
    cyc(B, o_wb(3), "b_ld_wb");

    // store faulting on its last access cycle, trap returns to fetch
    inb.ld = 1'b0; inb.st = 1'b1;
    cyc(B, o_frd(3), "b_st_f0");
    cyc(B, o_fdone(3), "b_st_f1");
    cyc(B, o_idle(3), "b_st_dec");
    cyc(B, o_ex(3, 1'b0, 2'd0, 2'd1), "b_st_ex");
    cyc(B, o_mem(1'b0, 1'b1, 3), "b_st_m0");
    inb.fc = 1'b1;
    cyc(B, o_mem(1'b0, 1'b0, 3), "b_st_fc");
    inb.fc = 1'b0;
    cyc(B, o_trap(3'd3, 3), "b_st_trap");
    cyc(B, o_frd(3), "b_st_next");
    cyc(B, o_fdone(3), "b_sys_f");

    inb.st = 1'b0; inb.sy = 1'b1;
    cyc(B, o_idle(3), "b_sys_dec");
    cyc(B, o_idle(3), "b_sys_ex");
    cyc(B, o_trap(3'd4, 3), "b_sys_trap");
    cyc(B, o_frd(3), "b_sys_next");
    cyc(B, o_fdone(3), "b_lui_f");

    inb.sy = 1'b0; inb.lu = 1'b1;
    cyc(B, o_idle(3), "b_lui_dec");
    cyc(B, o_ex(3, 1'b1, 2'd2, 2'd1), "b_lui_ex");
    cyc(B, o_frd(3), "b_lui_next");
    cyc(B, o_fdone(3), "b_aui_f");

    inb.lu = 1'b0; inb.au = 1'b1;
    cyc(B, o_idle(3), "b_aui_dec");
    cyc(B, o_ex(3, 1'b1, 2'd3, 2'd1), "b_aui_ex");
    cyc(B, o_frd(3), "b_aui_next");
    cyc(B, o_fdone(3), "b_imm_f");

    inb.au = 1'b0; inb.oi = 1'b1; inb.aluop = 5'h11;
    cyc(B, o_idle(3), "b_imm_dec");
    cyc(B, o_ex(5'h11, 1'b1, 2'd0, 2'd1), "b_imm_ex");
    cyc(B, o_frd(3), "b_imm_next");
    cyc(B, o_fdone(3), "b_misc_f");

    inb.oi = 1'b0; inb.mm = 1'b1;
    cyc(B, o_idle(3), "b_misc_dec");
    cyc(B, o_idle(3), "b_misc_ex");
    cyc(B, o_frd(3), "b_misc_next");
    cyc(B, o_fdone(3), "b_rl_f");

    // reset asserted in the middle of a memory access
    inb.mm = 1'b0; inb.ld = 1'b1;
    cyc(B, o_idle(3), "b_rl_dec");
    cyc(B, o_ex(3, 1'b0, 2'd0, 2'd1), "b_rl_ex");
    cyc(B, o_mem(1'b1, 1'b0, 3), "b_rl_m0");
    rst_n = 1'b0;
    cyc(B, ZERO, "b_rl_rst");
    rst_n = 1'b1;
    cyc(B, o_frd(3), "b_rl_f0");
    cyc(B, o_fdone(3), "b_rl_f1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
